// File: rtl/eeg_aram_rd_agen_pkg.sv
// Shared EEG package for the ARAM read address generator.
// Holds the default bus widths, the default return-FIFO depth and the
// FSM state encoding used by eeg_aram_rd_agen.
package eeg_aram_rd_agen_pkg;

  // ARAM word-address width and data width.
  localparam int EEG_ADD_AW  = 12;
  localparam int EEG_DAT_DW  = 8;
  // Return-FIFO depth (power of two, at least 2).
  localparam int EEG_FIFO_DP = 4;

  // Job FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // waiting for a job
    ST_ISSUE = 2'd1,  // issuing read addresses
    ST_DRAIN = 2'd2   // all addresses issued, forwarding remaining data
  } agen_state_e;

endpackage

// File: rtl/eeg_aram_rd_agen_if.sv
// Bus bundle for eeg_aram_rd_agen.
// Groups the job configuration handshake, the read-address stream to the
// ARAM bank, the read-data return stream and the output stream to the PE
// array, plus the is_idle/done status lines.
//   master : the address generator side
//   slave  : the environment (job source, ARAM bank, consumer)
interface eeg_aram_rd_agen_if
  import eeg_aram_rd_agen_pkg::*;
#(
  parameter int AW = EEG_ADD_AW,
  parameter int DW = EEG_DAT_DW
);

  // Job configuration
  logic          cfg_vld;
  logic          cfg_rdy;
  logic [AW-1:0] cfg_base;
  logic [AW-1:0] cfg_strd;
  logic [AW-1:0] cfg_cnt;

  // Read-address stream to the ARAM bank
  logic          add_vld;
  logic          add_lst;
  logic          add_rdy;
  logic [AW-1:0] add_add;

  // Read-data return from the ARAM bank
  logic          dat_vld;
  logic          dat_lst;
  logic          dat_rdy;
  logic [DW-1:0] dat_dat;

  // Output stream to the consumer
  logic          out_vld;
  logic          out_lst;
  logic          out_rdy;
  logic [DW-1:0] out_dat;

  // Status
  logic          is_idle;
  logic          done;

  modport master (
    input  cfg_vld, cfg_base, cfg_strd, cfg_cnt,
    output cfg_rdy,
    output add_vld, add_lst, add_add,
    input  add_rdy,
    input  dat_vld, dat_lst, dat_dat,
    output dat_rdy,
    output out_vld, out_lst, out_dat,
    input  out_rdy,
    output is_idle, done
  );

  modport slave (
    output cfg_vld, cfg_base, cfg_strd, cfg_cnt,
    input  cfg_rdy,
    input  add_vld, add_lst, add_add,
    output add_rdy,
    output dat_vld, dat_lst, dat_dat,
    input  dat_rdy,
    input  out_vld, out_lst, out_dat,
    output out_rdy,
    input  is_idle, done
  );

endinterface

// File: rtl/eeg_sync_fifo.sv
// Synchronous FIFO with registered storage, used as the ARAM return buffer.
// A word pushed at a clock edge is visible on o_vld/o_dat right after that
// edge. Simultaneous push and pop are accepted when full (the pop frees the
// slot) and when empty (only the push takes effect, since nothing is popped).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_dat (ignored when full without a pop)
//   i_dat      : write data
//   i_pop      : consume the head entry (ignored when empty)
//   o_vld      : FIFO non-empty
//   o_dat      : head entry
//   o_cnt      : current occupancy, 0..DP
module eeg_sync_fifo #(
  parameter int DW = 8,
  parameter int DP = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_push,
  input  logic [DW-1:0]       i_dat,
  input  logic                i_pop,
  output logic                o_vld,
  output logic [DW-1:0]       o_dat,
  output logic [$clog2(DP):0] o_cnt
);

  localparam int          PW    = $clog2(DP);
  localparam logic [PW:0] DEPTH = (PW + 1)'(DP);

  logic [DW-1:0] r_mem [DP];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [PW:0]   r_cnt;

  logic w_push;
  logic w_pop;

  assign w_pop  = i_pop && (r_cnt != '0);
  assign w_push = i_push && ((r_cnt != DEPTH) || w_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // NOTE: the storage array has no reset; the pointers and count define
  // which entries are meaningful, and a reset-free array maps onto RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_dat;
  end

  assign o_vld = (r_cnt != '0);
  assign o_dat = r_mem[r_rd];
  assign o_cnt = r_cnt;

endmodule

// File: rtl/eeg_aram_rd_agen.sv
// ARAM read address generator.
// Accepts a strided read job {base, strd, cnt}, issues cnt+1 read addresses
// base + i*strd (wrapping at 2^ADD_AW) to one ARAM bank, buffers the returned
// words in a return FIFO and forwards them in order to the consumer.
// Address issue is credit-limited so every outstanding read is guaranteed a
// FIFO slot: consumer back-pressure throttles issue and never drops data.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : master view of eeg_aram_rd_agen_if (cfg / add / dat / out
//                streams, is_idle, done)
module eeg_aram_rd_agen
  import eeg_aram_rd_agen_pkg::*;
#(
  parameter int ADD_AW  = EEG_ADD_AW,
  parameter int DAT_DW  = EEG_DAT_DW,
  parameter int FIFO_DP = EEG_FIFO_DP
) (
  input logic               clk,
  input logic               rst_n,
  eeg_aram_rd_agen_if.master bus
);

  // Outstanding-read counter width: holds 0..FIFO_DP.
  localparam int          OW   = $clog2(FIFO_DP) + 1;
  localparam logic [OW:0] DP_W = (OW + 1)'(FIFO_DP);

  agen_state_e       r_state;
  logic [ADD_AW-1:0] r_add;    // running address, starts at base
  logic [ADD_AW-1:0] r_strd;
  logic [ADD_AW-1:0] r_cnt;
  logic [ADD_AW-1:0] r_idx;    // index of the word currently offered
  logic [OW-1:0]     r_outst;  // reads issued but not yet returned
  logic              r_done;

  logic              w_credit;
  logic              w_add_hs;
  logic              w_dat_hs;
  logic              w_out_hs;
  logic              w_fifo_vld;
  logic [DAT_DW:0]   w_fifo_dat;
  logic [OW-1:0]     w_fifo_cnt;

  // A new read is allowed only if every read already in flight plus every
  // word already buffered still leaves a free FIFO slot for it.
  assign w_credit = ({1'b0, r_outst} + {1'b0, w_fifo_cnt}) < DP_W;

  assign bus.cfg_rdy = (r_state == ST_IDLE);
  assign bus.is_idle = (r_state == ST_IDLE);

  assign bus.add_vld = (r_state == ST_ISSUE) && w_credit;
  assign bus.add_lst = (r_state == ST_ISSUE) && (r_idx == r_cnt);
  assign bus.add_add = r_add;

  // Returns are accepted whenever a job is active; the credit rule ensures
  // the FIFO has room. A return while idle is dropped.
  assign bus.dat_rdy = (r_state != ST_IDLE);

  assign bus.out_vld = w_fifo_vld;
  assign bus.out_dat = w_fifo_dat[DAT_DW-1:0];
  assign bus.out_lst = w_fifo_vld && w_fifo_dat[DAT_DW];
  assign bus.done    = r_done;

  assign w_add_hs = bus.add_vld && bus.add_rdy;
  assign w_dat_hs = bus.dat_vld && bus.dat_rdy;
  assign w_out_hs = bus.out_vld && bus.out_rdy;

  // Job FSM with the address accumulator and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_add   <= '0;
      r_strd  <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.cfg_vld) begin
            r_add   <= bus.cfg_base;
            r_strd  <= bus.cfg_strd;
            r_cnt   <= bus.cfg_cnt;
            r_idx   <= '0;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (w_add_hs) begin
            // Accumulate instead of multiplying; wrap is silent.
            r_add <= r_add + r_strd;
            r_idx <= r_idx + 1'b1;
            if (bus.add_lst) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_out_hs && bus.out_lst) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Outstanding reads: up on address handshake, down on data handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outst <= '0;
    end else begin
      case ({w_add_hs, w_dat_hs})
        2'b10:   r_outst <= r_outst + 1'b1;
        2'b01:   r_outst <= r_outst - 1'b1;
        default: r_outst <= r_outst;
      endcase
    end
  end

  // Return buffer holds {lst, data}.
  eeg_sync_fifo #(
    .DW (DAT_DW + 1),
    .DP (FIFO_DP)
  ) u_ret_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_dat_hs),
    .i_dat  ({bus.dat_lst, bus.dat_dat}),
    .i_pop  (w_out_hs),
    .o_vld  (w_fifo_vld),
    .o_dat  (w_fifo_dat),
    .o_cnt  (w_fifo_cnt)
  );

endmodule

// File: tb/tb_eeg_aram_rd_agen.sv
// Testbench for eeg_aram_rd_agen: expected address and output words are
// queued when a job is issued; a monitor pops and compares them on every
// add and out handshake. An ARAM model returns words in order with a
// programmable latency.
module tb_eeg_aram_rd_agen;
  import eeg_aram_rd_agen_pkg::*;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int DP = 4;

  typedef struct packed {
    logic [AW-1:0] add;
    logic          lst;
  } add_exp_t;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic          lst;
  } out_exp_t;

  typedef struct packed {
    logic [AW-1:0] add;
    logic          lst;
    logic [31:0]   due;
  } aram_req_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  eeg_aram_rd_agen_if #(.AW(AW), .DW(DW)) bus ();

  eeg_aram_rd_agen #(
    .ADD_AW  (AW),
    .DAT_DW  (DW),
    .FIFO_DP (DP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  add_exp_t    exp_add_q[$];
  out_exp_t    exp_out_q[$];
  aram_req_t   aram_q[$];

  int unsigned add_rdy_pct = 100;
  int unsigned out_rdy_pct = 100;
  bit          add_hold    = 1'b0;
  bit          out_hold    = 1'b0;
  int unsigned lat         = 1;
  int unsigned cyc         = 0;
  int          issued      = 0;
  int          consumed    = 0;
  int          n_done      = 0;
  int          done_mark   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ARAM content: low address byte plus 0x33.
  function automatic logic [DW-1:0] aram_word(input logic [AW-1:0] a);
    return a[7:0] + 8'h33;
  endfunction

  task automatic push_exp(input logic [AW-1:0] a, input logic l, input logic [DW-1:0] d);
    exp_add_q.push_back('{add: a, lst: l});
    exp_out_q.push_back('{dat: d, lst: l});
  endtask

  // Reference model for strided jobs: address i = base + i*strd mod 2^AW.
  task automatic model_job(input logic [AW-1:0] base, input logic [AW-1:0] strd,
                           input logic [AW-1:0] cnt);
    logic [AW-1:0] a;
    for (int i = 0; i <= int'(cnt); i++) begin
      a = AW'(int'(base) + i * int'(strd));
      push_exp(a, (i == int'(cnt)), aram_word(a));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_is_idle"}, bus.is_idle, 1);
    check({tag, "_cfg_rdy"}, bus.cfg_rdy, 1);
    check({tag, "_add_vld"}, bus.add_vld, 0);
    check({tag, "_add_lst"}, bus.add_lst, 0);
    check({tag, "_dat_rdy"}, bus.dat_rdy, 0);
    check({tag, "_out_vld"}, bus.out_vld, 0);
    check({tag, "_out_lst"}, bus.out_lst, 0);
    check({tag, "_done"},    bus.done,    0);
  endtask

  task automatic start_job(input string name, input logic [AW-1:0] base,
                           input logic [AW-1:0] strd, input logic [AW-1:0] cnt);
    int t = 0;
    @(negedge clk); #1;
    while (!bus.cfg_rdy && t < 200) begin
      @(negedge clk); #1;
      t++;
    end
    check({name, "_cfg_rdy"}, bus.cfg_rdy, 1);
    done_mark     = n_done;
    bus.cfg_base  = base;
    bus.cfg_strd  = strd;
    bus.cfg_cnt   = cnt;
    bus.cfg_vld   = 1'b1;
    @(posedge clk); #1;
    bus.cfg_vld   = 1'b0;
  endtask

  task automatic wait_job(input string name, input int budget);
    int t = 0;
    while (n_done == done_mark && t < budget) begin
      @(negedge clk); #1;
      t++;
    end
    check({name, "_done_seen"}, (n_done != done_mark), 1);
    repeat (2) begin
      @(negedge clk); #1;
    end
    check({name, "_done_once"}, n_done - done_mark, 1);
    check({name, "_add_left"},  exp_add_q.size(), 0);
    check({name, "_out_left"},  exp_out_q.size(), 0);
  endtask

  task automatic flush_model();
    exp_add_q.delete();
    exp_out_q.delete();
    issued   = 0;
    consumed = 0;
  endtask

  // Cycle counter: number of rising edges so far.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Ready drivers for the address and output streams.
  initial begin
    bus.add_rdy = 1'b0;
    bus.out_rdy = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.add_rdy = !add_hold && ($urandom_range(99) < add_rdy_pct);
      bus.out_rdy = !out_hold && ($urandom_range(99) < out_rdy_pct);
    end
  end

  // ARAM bank model: in-order returns, each at least lat cycles after its
  // address was accepted.
  initial begin
    bit hs;
    bus.dat_vld = 1'b0;
    bus.dat_lst = 1'b0;
    bus.dat_dat = '0;
    forever begin
      @(negedge clk);
      hs = bus.dat_vld && bus.dat_rdy;
      if (rst_n && bus.add_vld && bus.add_rdy)
        aram_q.push_back('{add: bus.add_add, lst: bus.add_lst, due: cyc + lat});
      @(posedge clk); #1;
      if (!rst_n) begin
        aram_q.delete();
      end else if (hs && aram_q.size() > 0) begin
        void'(aram_q.pop_front());
      end
      if (rst_n && aram_q.size() > 0 && aram_q[0].due <= cyc) begin
        bus.dat_vld = 1'b1;
        bus.dat_lst = aram_q[0].lst;
        bus.dat_dat = aram_word(aram_q[0].add);
      end else begin
        bus.dat_vld = 1'b0;
        bus.dat_lst = 1'b0;
      end
    end
  end

  // Monitor: sampled on the falling edge, so a handshake seen here is the one
  // taken at the next rising edge.
  initial begin
    logic [AW-1:0] prev_add;
    logic          prev_lst;
    bit            prev_stall;
    bit            exp_done;
    add_exp_t      ea;
    out_exp_t      eo;
    prev_add   = '0;
    prev_lst   = 1'b0;
    prev_stall = 1'b0;
    exp_done   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        exp_done   = 1'b0;
      end else begin
        if (prev_stall) begin
          check("add_add_hold", bus.add_add, prev_add);
          check("add_lst_hold", bus.add_lst, prev_lst);
        end
        prev_stall = bus.add_vld && !bus.add_rdy;
        prev_add   = bus.add_add;
        prev_lst   = bus.add_lst;

        if (bus.done || exp_done) check("done_pulse", bus.done, exp_done);
        if (bus.done) n_done++;
        exp_done = 1'b0;

        if (bus.add_vld && bus.add_rdy) begin
          check("credit", (issued - consumed) < DP, 1);
          issued++;
          check("add_expected", exp_add_q.size() != 0, 1);
          if (exp_add_q.size() != 0) begin
            ea = exp_add_q.pop_front();
            check("add_add", bus.add_add, ea.add);
            check("add_lst", bus.add_lst, ea.lst);
          end
        end

        if (bus.out_vld && bus.out_rdy) begin
          consumed++;
          check("out_expected", exp_out_q.size() != 0, 1);
          if (exp_out_q.size() != 0) begin
            eo = exp_out_q.pop_front();
            check("out_dat", bus.out_dat, eo.dat);
            check("out_lst", bus.out_lst, eo.lst);
          end
          if (bus.out_lst) exp_done = 1'b1;
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors",
             n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  // Directed and randomized job sequence.
  initial begin
    int t;
    int iss0;
    rst_n        = 1'b0;
    bus.cfg_vld  = 1'b0;
    bus.cfg_base = '0;
    bus.cfg_strd = '0;
    bus.cfg_cnt  = '0;

    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Unit stride, ARAM latency 1.
    lat = 1;
    push_exp(12'h010, 1'b0, 8'h43);
    push_exp(12'h011, 1'b0, 8'h44);
    push_exp(12'h012, 1'b0, 8'h45);
    push_exp(12'h013, 1'b1, 8'h46);
    start_job("unit", 12'h010, 12'd1, 12'd3);
    wait_job("unit", 200);

    // Address wrap.
    push_exp(12'hFFE, 1'b0, 8'h31);
    push_exp(12'h001, 1'b0, 8'h34);
    push_exp(12'h004, 1'b1, 8'h37);
    start_job("wrap", 12'hFFE, 12'd3, 12'd2);
    wait_job("wrap", 200);

    // Zero stride repeats the base.
    push_exp(12'h123, 1'b0, 8'h56);
    push_exp(12'h123, 1'b0, 8'h56);
    push_exp(12'h123, 1'b1, 8'h56);
    start_job("strd0", 12'h123, 12'd0, 12'd2);
    wait_job("strd0", 200);

    // Single word with address stalled for 5 cycles.
    add_hold = 1'b1;
    push_exp(12'h7A0, 1'b1, 8'hD3);
    start_job("single", 12'h7A0, 12'd5, 12'd0);
    repeat (5) begin
      @(negedge clk); #1;
      check("single_stall_vld", bus.add_vld, 1);
    end
    add_hold = 1'b0;
    wait_job("single", 200);

    // Consumer blocked: credit stops issue after FIFO_DP addresses.
    lat      = 3;
    out_hold = 1'b1;
    iss0     = issued;
    model_job(12'h200, 12'd2, 12'd7);
    start_job("bp", 12'h200, 12'd2, 12'd7);
    repeat (20) begin
      @(negedge clk); #1;
    end
    check("bp_issued", issued - iss0, 4);
    check("bp_add_vld", bus.add_vld, 0);
    check("bp_out_vld", bus.out_vld, 1);
    out_hold = 1'b0;
    wait_job("bp", 400);

    // Full-range count: 2^ADD_AW words.
    lat = 1;
    model_job(12'h5A5, 12'd1, 12'hFFF);
    start_job("full", 12'h5A5, 12'd1, 12'hFFF);
    wait_job("full", 20000);

    // Reset in the middle of issue after two addresses.
    lat  = 3;
    iss0 = issued;
    model_job(12'h300, 12'd1, 12'd7);
    start_job("midrst", 12'h300, 12'd1, 12'd7);
    t = 0;
    while ((issued - iss0) < 2 && t < 100) begin
      @(negedge clk); #1;
      t++;
    end
    check("midrst_two_issued", issued - iss0, 2);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    flush_model();
    repeat (2) @(negedge clk);
    check_reset_outputs("midrst_hold");
    rst_n = 1'b1;
    lat   = 1;
    model_job(12'h040, 12'd4, 12'd3);
    start_job("after_rst", 12'h040, 12'd4, 12'd3);
    wait_job("after_rst", 200);

    // Randomized jobs with random ready and latency.
    for (int j = 0; j < 1000; j++) begin
      logic [AW-1:0] b, s, c;
      b           = AW'($urandom);
      s           = ($urandom_range(3) == 0) ? '0 : AW'($urandom);
      c           = AW'($urandom_range(7));
      lat         = $urandom_range(1, 4);
      add_rdy_pct = $urandom_range(40, 100);
      out_rdy_pct = $urandom_range(30, 100);
      model_job(b, s, c);
      start_job("rand", b, s, c);
      wait_job("rand", 600);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/eeg_aram_rd_agen.md
EEG_ARAM_RD_AGEN -- requirements
Module: eeg_aram_rd_agen

Interface
REQ-001 SHALL have parameter ADD_AW, default 12: ARAM word-address width.
REQ-002 SHALL have parameter DAT_DW, default 8: ARAM data width.
REQ-003 SHALL have parameter FIFO_DP, default 4: return-FIFO depth, power of two, at least 2.
REQ-004 clk  in  1  clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 cfg_vld / cfg_rdy  in / out  1 / 1  job handshake.
REQ-007 cfg_base  in  ADD_AW  first word address.
REQ-008 cfg_strd  in  ADD_AW  address increment per word.
REQ-009 cfg_cnt  in  ADD_AW  number of words minus 1.
REQ-010 add_vld / add_lst / add_rdy  out / out / in  1 each  read-address stream to one ARAM bank.
REQ-011 add_add  out  ADD_AW  read address.
REQ-012 dat_vld / dat_lst / dat_rdy  in / in / out  1 each  read-data return from the ARAM bank.
REQ-013 dat_dat  in  DAT_DW  returned word.
REQ-014 out_vld / out_lst / out_rdy  out / out / in  1 each  stream to consumer (PE array).
REQ-015 out_dat  out  DAT_DW  forwarded word.
REQ-016 is_idle  out  1  high in IDLE.
REQ-017 done  out  1  one-cycle pulse when the last word is accepted by the consumer.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, DRAIN.
REQ-019 cfg_rdy SHALL equal is_idle; cfg_vld&cfg_rdy SHALL latch base/strd/cnt, zero the word index and move to ISSUE.
REQ-020 In ISSUE, add_vld SHALL be high iff credit is available, where credit = (outstanding + FIFO occupancy) < FIFO_DP.
REQ-021 add_add SHALL be (base + index*strd) mod 2^ADD_AW, computed by accumulation with silent wrap.
REQ-022 add_lst SHALL be high iff index == cnt.
REQ-023 add_add/add_lst SHALL hold stable while add_vld&~add_rdy.
REQ-024 On add_vld&add_rdy&add_lst, the FSM SHALL go ISSUE->DRAIN.
REQ-025 The outstanding counter SHALL increment on add handshake and decrement on dat handshake; simultaneous events SHALL leave it unchanged.
REQ-026 The outstanding counter SHALL be $clog2(FIFO_DP)+1 bits wide.
REQ-027 dat_rdy SHALL be high in ISSUE and DRAIN; the credit rule guarantees FIFO space for every return.
REQ-028 A return in IDLE is a protocol error; the FIFO SHALL drop it.
REQ-029 The return FIFO SHALL store {dat_lst, dat_dat}.
REQ-030 The FIFO SHALL support simultaneous push and pop when full or empty.
REQ-031 out_vld SHALL be FIFO non-empty, and out_dat/out_lst SHALL be the head entry.
REQ-032 Latency: a word returned in cycle t SHALL appear on out_vld at t+1 (registered FIFO).
REQ-033 In DRAIN, an out_vld&out_rdy&out_lst handshake SHALL pulse done and return the FSM to IDLE; outstanding and FIFO SHALL be empty at that point.
REQ-034 cnt=0 SHALL issue exactly one address with add_lst=1.
REQ-035 cnt=2^ADD_AW-1 SHALL issue 2^ADD_AW addresses; the index counter is ADD_AW bits.
REQ-036 strd=0 SHALL repeatedly issue base.
REQ-037 Back-pressure on out_rdy SHALL throttle address issue via credit only, never dropping data.

Reset
REQ-038 rst_n low SHALL asynchronously clear FSM to IDLE, counters, FIFO pointers and latched config.
REQ-039 During reset, is_idle and cfg_rdy SHALL be 1, and add_vld, add_lst, dat_rdy, out_vld, out_lst, done SHALL be 0.
REQ-040 Reset mid-job SHALL abandon the job with no further add_vld; the consumer discards its partial stream.

Structure
REQ-041 FSM state encodings and the ADD_AW/DAT_DW defaults SHALL live in the shared EEG package.
REQ-042 The return FIFO SHALL be one sub-module, eeg_sync_fifo (parameters DW, DP).

Verification
REQ-043 base=0x010, strd=1, cnt=3, add_rdy=out_rdy=1, ARAM latency 1 -> addresses 0x010..0x013, lst on 0x013, four out words, done one cycle after the last out handshake.
REQ-044 base=0xFFE, strd=3, cnt=2 -> addresses 0xFFE, 0x001, 0x004 (wrap).
REQ-045 FIFO_DP=4, out_rdy=0, ARAM latency 3 -> exactly 4 addresses issued, then add_vld=0; release out_rdy -> remaining words flow with no loss or reorder.
REQ-046 cnt=0 with add_rdy low for 5 cycles -> add_add/add_lst stable; single word with out_lst=1; done pulses once.
REQ-047 Assert rst_n low mid-ISSUE after 2 of 8 addresses -> outputs at reset values; a new cfg accepted next cycle after release runs cleanly.
REQ-048 Random add_rdy/dat latency/out_rdy over 1000 jobs -> scoreboard order and values match, outstanding never exceeds FIFO_DP.
